// File: rtl/spi_frontend_pkg.sv
// spi_frontend_pkg: shared defaults and idle levels for the SPI input front end.
package spi_frontend_pkg;
  localparam int DEFAULT_WAIT_TIME = 3;
  localparam int DEFAULT_COUNTER_WIDTH = 8;
  localparam logic CS_IDLE = 1'b1;
endpackage

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes one raw pin, debounces it into a conditioned
// level, and emits one-cycle pulses on each conditioned rising/falling change.
module input_conditioner
  import spi_frontend_pkg::*;
#(
  parameter int WAIT_TIME = DEFAULT_WAIT_TIME,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_cond,
  output logic o_posedge,
  output logic o_negedge
);
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(WAIT_TIME - 1);
  logic r_sync1, r_sync2, r_cond, r_pos, r_neg;
  logic [COUNTER_WIDTH-1:0] r_cnt;
  logic w_diff, w_flip;
  assign w_diff = r_sync2 != r_cond;
  // a change is accepted on the WAIT_TIME-th consecutive mismatching evaluation
  assign w_flip = w_diff && (r_cnt == LAST);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
      r_cond  <= RESET_VALUE;
      r_cnt   <= '0;
      r_pos   <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_cnt   <= (w_diff && !w_flip) ? r_cnt + 1'b1 : '0;
      r_cond  <= w_flip ? r_sync2 : r_cond;
      r_pos   <= w_flip && r_sync2;
      r_neg   <= w_flip && !r_sync2;
    end
  end
  assign o_cond    = r_cond;
  assign o_posedge = r_pos;
  assign o_negedge = r_neg;
endmodule

// File: rtl/spi_input_frontend.sv
// spi_input_frontend: conditions raw SCLK, CS and MOSI pins for the SPI slave
// core; SCLK edges become single-cycle pulses, CS and MOSI become clean levels.
module spi_input_frontend
  import spi_frontend_pkg::*;
#(
  parameter int WAIT_TIME = DEFAULT_WAIT_TIME,
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic noisy_sclk,
  input  logic noisy_cs,
  input  logic noisy_mosi,
  output logic sclk_posedge,
  output logic sclk_negedge,
  output logic cs_cond,
  output logic mosi_cond
);
  logic w_unused_sclk_cond, w_unused_cs_pos, w_unused_cs_neg;
  logic w_unused_mosi_pos, w_unused_mosi_neg;
  input_conditioner #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .RESET_VALUE(1'b0)
  ) u_sclk (
    .clk(clk), .reset_n(reset_n), .i_raw(noisy_sclk), .o_cond(w_unused_sclk_cond),
    .o_posedge(sclk_posedge), .o_negedge(sclk_negedge)
  );
  input_conditioner #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .RESET_VALUE(CS_IDLE)
  ) u_cs (
    .clk(clk), .reset_n(reset_n), .i_raw(noisy_cs), .o_cond(cs_cond),
    .o_posedge(w_unused_cs_pos), .o_negedge(w_unused_cs_neg)
  );
  input_conditioner #(
    .WAIT_TIME(WAIT_TIME), .COUNTER_WIDTH(COUNTER_WIDTH), .RESET_VALUE(1'b0)
  ) u_mosi (
    .clk(clk), .reset_n(reset_n), .i_raw(noisy_mosi), .o_cond(mosi_cond),
    .o_posedge(w_unused_mosi_pos), .o_negedge(w_unused_mosi_neg)
  );
endmodule

// File: doc/spi_input_frontend.md
SPI_INPUT_FRONTEND -- requirements
Module: spi_input_frontend

Interface
REQ-001 The block SHALL have parameter WAIT_TIME, default 3: consecutive mismatched samples required before a conditioned output changes; legal range 1..255.
REQ-002 The block SHALL have parameter COUNTER_WIDTH, default 8: width of each debounce counter; must hold WAIT_TIME-1.
REQ-003 The block SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port noisy_sclk, input, 1: raw, asynchronous SPI serial clock pin.
REQ-006 The block SHALL have port noisy_cs, input, 1: raw, asynchronous active-low SPI chip select pin.
REQ-007 The block SHALL have port noisy_mosi, input, 1: raw, asynchronous SPI MOSI pin.
REQ-008 The block SHALL have port sclk_posedge, output, 1: one-cycle pulse on a conditioned SCLK rising transition; drives the FSM SCLKEdge input.
REQ-009 The block SHALL have port sclk_negedge, output, 1: one-cycle pulse on a conditioned SCLK falling transition; drives MISO shift timing.
REQ-010 The block SHALL have port cs_cond, output, 1: conditioned chip select, 1 = deselected; drives the FSM ChipSelCond input.
REQ-011 The block SHALL have port mosi_cond, output, 1: conditioned MOSI data for the input shift register.

Function
REQ-012 Each channel SHALL pass its raw input through a two-flop synchronizer (sync1, sync2) before any use.
REQ-013 Each channel SHALL hold a conditioned value cond and a counter cnt, updated on each clk edge as follows.
REQ-014 If sync2 == cond, cnt SHALL load 0 and cond SHALL hold.
REQ-015 If sync2 != cond and cnt == WAIT_TIME-1, cond SHALL load sync2, cnt SHALL load 0, and exactly one edge pulse SHALL assert for the next cycle.
REQ-016 If sync2 != cond and cnt < WAIT_TIME-1, cnt SHALL increment by 1 and cond SHALL hold.
REQ-017 Latency: an input change sampled at edge k and held stable SHALL appear on cond after edge k+WAIT_TIME+1, with the pulse in the same cycle.
REQ-018 A glitch that produces fewer than WAIT_TIME consecutive mismatched evaluations SHALL leave cond unchanged, with no pulse and cnt back to 0.
REQ-019 sclk_posedge SHALL be high for exactly one cycle when the SCLK cond goes 0->1; sclk_negedge SHALL be high for exactly one cycle when it goes 1->0; the two SHALL never be high together.
REQ-020 With WAIT_TIME=1, cond SHALL follow sync2 with one cycle of delay, and a pulse SHALL accompany every change.
REQ-021 Channels SHALL be independent; simultaneous changes on all pins SHALL update all conds in the same cycle.
REQ-022 The counter SHALL never exceed WAIT_TIME-1 and SHALL never wrap.

Reset
REQ-023 While reset_n=0, the sclk and mosi channels SHALL hold sync1, sync2 and cond at 0; the cs channel SHALL hold them at 1; all cnt SHALL be 0; sclk_posedge and sclk_negedge SHALL be 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count and suppress any pending pulse.
REQ-025 After reset_n deasserts, the first input evaluation SHALL occur at the next clk edge.

Structure
REQ-026 Package spi_frontend_pkg SHALL hold the default WAIT_TIME, the default COUNTER_WIDTH, and the cs idle level constant.
REQ-027 Sub-module input_conditioner SHALL implement one channel (synchronizer, counter, cond, posedge/negedge pulses), with a RESET_VALUE parameter; it SHALL be instantiated three times.

Verification
REQ-028 Reset, then hold pins at idle -> cs_cond=1, mosi_cond=0, no pulses for 100 cycles.
REQ-029 With WAIT_TIME=3, noisy_sclk 0->1 sampled at edge k and held -> sclk_posedge high only in the cycle after edge k+4; later 1->0 -> a single sclk_negedge pulse at the same latency.
REQ-030 With WAIT_TIME=3, a noisy_mosi pulse 2 cycles wide -> mosi_cond stays 0 and cnt returns to 0.
REQ-031 noisy_cs 1->0 held, plus SCLK toggling every 10 cycles -> cs_cond=0 after 4 edges and one posedge/negedge pulse per SCLK half-period, none missed.
REQ-032 Assert reset_n=0 when the SCLK cnt is 2 -> cnt=0, no pulse, cond=0 immediately.
REQ-033 With WAIT_TIME=1, noisy_sclk toggled every 2 cycles -> every transition produces a pulse, each 2 cycles after sampling.
